// File: rtl/atb_pkg.sv
// Shared ATB widths, flush FSM encoding and the reserved trace-ID check.
package atb_pkg;
   localparam int ATB_DATA_W  = 32;
   localparam int ATB_BYTES_W = 3;
   localparam int ATB_ID_W    = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2
   } flush_state_e;

   // IDs 0x00, 0x70-0x7C, 0x7E and 0x7F are reserved by the trace architecture
   function automatic logic atid_reserved(input logic [ATB_ID_W-1:0] id);
      return (id == 7'h00) || ((id >= 7'h70) && (id <= 7'h7C)) || (id >= 7'h7E);
   endfunction
endpackage

// File: rtl/atb_if.sv
// ATB bundle between a trace source (master) and a trace sink (slave).
interface atb_if;
   import atb_pkg::*;

   logic [ATB_DATA_W-1:0]  atdata;
   logic [ATB_BYTES_W-1:0] atbytes;
   logic [ATB_ID_W-1:0]    atid;
   logic                   atvalid;
   logic                   atready;
   logic                   afvalid;
   logic                   afready;
   logic                   syncreq;
   logic                   atwakeup;

   modport master (
      output atdata, atbytes, atid, atvalid, afready, atwakeup,
      input  atready, afvalid, syncreq
   );

   modport slave (
      input  atdata, atbytes, atid, atvalid, afready, atwakeup,
      output atready, afvalid, syncreq
   );
endinterface

// File: rtl/atb_sync_fifo.sv
// Small FIFO with clock enable. Pointers carry an extra wrap bit so full and
// empty are distinguishable; the head is read combinationally so the consumer
// can register it on the very next edge.
module atb_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clken_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is fine when the head leaves in the same cycle
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Pointer advance; wraps naturally because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
   end

   // Pointer registers, held while the clock enable is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clken_i) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset so it maps onto distributed RAM
   always_ff @(posedge clk) begin
      if (clken_i && do_push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
      end
   end
endmodule

// File: rtl/atb_trace_source.sv
// ATB trace source: buffers generator words, drives them onto ATB, services
// sink flushes and latches sync requests. Optional transfer/drop/flush
// counters are compiled in with ATB_TRACE_SOURCE_STATS_EN.
module atb_trace_source
   import atb_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = ATB_DATA_W,
   parameter int BYTES_W = ATB_BYTES_W
) (
   input  logic                atclk,
   input  logic                atresetn,
   input  logic                atclken,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [BYTES_W-1:0]  in_bytes,
   input  logic [ATB_ID_W-1:0] cfg_atid,
   input  logic                cfg_en,
   output logic                cfg_err,
   atb_if.master               atb,
   output logic                sync_pending,
   input  logic                sync_ack
`ifdef ATB_TRACE_SOURCE_STATS_EN
   ,
   output logic [31:0]         stat_xfer,
   output logic [15:0]         stat_drop,
   output logic [15:0]         stat_flush
`endif
);
   localparam int ENTRY_W = DATA_W + BYTES_W;

   flush_state_e          state_q, state_d;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ENTRY_W-1:0]    fifo_wdata, fifo_rdata;
   logic [BYTES_W-1:0]    bytes_sat;
   logic                  tx_en, load, discard, xfer, in_accept;
   logic                  flush_ack, drain_mode, accept_block;
   logic                  atvalid_q, atvalid_d;
   logic [DATA_W-1:0]     atdata_q, atdata_d;
   logic [BYTES_W-1:0]    atbytes_q, atbytes_d;
   logic [ATB_ID_W-1:0]   atid_q, atid_d;
   logic                  cfg_err_q, sync_pending_q, atwakeup_q;

   // Reserved IDs are checked combinationally too so a freshly enabled bad ID
   // never slips a word out before cfg_err registers
   assign tx_en      = cfg_en && !cfg_err_q && !atid_reserved(cfg_atid);
   assign in_ready   = atresetn && !fifo_full && !accept_block;
   assign in_accept  = in_valid && in_ready;
   assign bytes_sat  = (in_bytes > BYTES_W'(3)) ? BYTES_W'(3) : in_bytes;
   // Zero words are padding: accepted but never stored
   assign fifo_push  = in_accept && (in_data != '0);
   assign fifo_wdata = {in_data, bytes_sat};
   assign xfer       = atvalid_q && atb.atready;
   assign load       = tx_en && !fifo_empty && (!atvalid_q || atb.atready);
   // A flush while transmission is blocked throws the queue away instead
   assign discard    = drain_mode && !tx_en && !fifo_empty;
   assign fifo_pop   = load || discard;

   atb_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (atclk),
      .rst_n   (atresetn),
      .clken_i (atclken),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Flush state register
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn)    state_q <= IDLE;
      else if (atclken) state_q <= state_d;
   end

   // Flush next state: drain until FIFO and output register are both clear
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (atb.afvalid) state_d = DRAIN;
         DRAIN:   if (fifo_empty && (!atvalid_q || atb.atready)) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Flush outputs decoded from the state
   always_comb begin
      flush_ack    = (state_q == ACK);
      drain_mode   = (state_q == DRAIN);
      accept_block = (state_q == ACK);
   end

   // Output register: load from head when free or being consumed, else hold
   always_comb begin
      atvalid_d = atvalid_q;
      atdata_d  = atdata_q;
      atbytes_d = atbytes_q;
      atid_d    = atid_q;
      if (load) begin
         atvalid_d = 1'b1;
         atdata_d  = fifo_rdata[ENTRY_W-1:BYTES_W];
         atbytes_d = fifo_rdata[BYTES_W-1:0];
         atid_d    = cfg_atid;
      end else if (xfer) begin
         atvalid_d = 1'b0;
      end
   end

   // ATB output and status registers
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         atvalid_q      <= 1'b0;
         atdata_q       <= '0;
         atbytes_q      <= '0;
         atid_q         <= '0;
         cfg_err_q      <= 1'b0;
         sync_pending_q <= 1'b0;
         atwakeup_q     <= 1'b0;
      end else if (atclken) begin
         atvalid_q      <= atvalid_d;
         atdata_q       <= atdata_d;
         atbytes_q      <= atbytes_d;
         atid_q         <= atid_d;
         cfg_err_q      <= cfg_en && atid_reserved(cfg_atid);
         // A new request outranks a simultaneous acknowledge
         sync_pending_q <= syncreq_set(atb.syncreq, sync_ack, sync_pending_q);
         atwakeup_q     <= atvalid_q || !fifo_empty || (state_q != IDLE);
      end
   end

   function automatic logic syncreq_set(input logic req, input logic ack, input logic cur);
      return req ? 1'b1 : (ack ? 1'b0 : cur);
   endfunction

   assign atb.atvalid  = atvalid_q;
   assign atb.atdata   = atdata_q;
   assign atb.atbytes  = atbytes_q;
   assign atb.atid     = atid_q;
   assign atb.afready  = flush_ack;
   assign atb.atwakeup = atwakeup_q;
   assign cfg_err      = cfg_err_q;
   assign sync_pending = sync_pending_q;

`ifdef ATB_TRACE_SOURCE_STATS_EN
   logic [31:0] stat_xfer_q;
   logic [15:0] stat_drop_q, stat_flush_q;

   // Saturating activity counters
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         stat_xfer_q  <= '0;
         stat_drop_q  <= '0;
         stat_flush_q <= '0;
      end else if (atclken) begin
         if (xfer && (stat_xfer_q != '1))                        stat_xfer_q  <= stat_xfer_q + 32'd1;
         if (in_accept && (in_data == '0) && (stat_drop_q != '1)) stat_drop_q  <= stat_drop_q + 16'd1;
         if (flush_ack && (stat_flush_q != '1))                  stat_flush_q <= stat_flush_q + 16'd1;
      end
   end

   assign stat_xfer  = stat_xfer_q;
   assign stat_drop  = stat_drop_q;
   assign stat_flush = stat_flush_q;
`endif
endmodule
